// File: rtl/lcd_pkg.sv
// Shared LCD types: buffer geometry, room codes, sequencer states.
// Also holds the fixed 16-character message lines and a char picker.
package lcd_pkg;

  localparam int LCD_ROWS = 2;
  localparam int LCD_COLS = 16;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    CAVE    = 3'd0,
    TUNNEL  = 3'd1,
    RIVER   = 3'd2,
    DUNGEON = 3'd3,
    VAULT   = 3'd4
  } room_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REQ,
    WAIT
  } seq_state_t;

  localparam logic [127:0] MSG_CAVE    = "Cave            ";
  localparam logic [127:0] MSG_TUNNEL  = "Tunnel          ";
  localparam logic [127:0] MSG_RIVER   = "River           ";
  localparam logic [127:0] MSG_DUNGEON = "Dungeon         ";
  localparam logic [127:0] MSG_VAULT   = "Vault           ";
  localparam logic [127:0] MSG_UNKNOWN = "????            ";
  localparam logic [127:0] MSG_SW_YES  = "Sword: YES      ";
  localparam logic [127:0] MSG_SW_NO   = "Sword: NO       ";
  localparam logic [127:0] MSG_BLANK   = {16{CHAR_SPACE}};

  // Leftmost character of a literal sits in the top byte.
  function automatic logic [7:0] str_char(
    input logic [127:0] s,
    input logic [3:0]   c
  );
    return s[8*(15-int'(c)) +: 8];
  endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Combinational message ROM: (rooms, sword, cell index) -> character.
// Row 0 carries the room name, row 1 the sword status, others blank.
module lcd_msg_rom
  import lcd_pkg::*;
#(
  parameter int ROWS = LCD_ROWS,
  parameter int COLS = LCD_COLS,
  parameter int IW   = $clog2(ROWS*COLS)
) (
  input  logic [2:0]    rooms,
  input  logic          sword,
  input  logic [IW-1:0] idx,
  output logic [7:0]    ch
);

  int          row;
  int          col;
  logic [127:0] line;
  logic [127:0] name;

  always_comb begin
    row = int'(idx) / COLS;
    col = int'(idx) % COLS;

    name = MSG_UNKNOWN;
    unique case (rooms)
      CAVE:    name = MSG_CAVE;
      TUNNEL:  name = MSG_TUNNEL;
      RIVER:   name = MSG_RIVER;
      DUNGEON: name = MSG_DUNGEON;
      VAULT:   name = MSG_VAULT;
      default: name = MSG_UNKNOWN;
    endcase

    line = MSG_BLANK;
    unique case (1'b1)
      (row == 0): line = name;
      (row == 1): line = sword ? MSG_SW_YES
                               : MSG_SW_NO;
      default:    line = MSG_BLANK;
    endcase

    ch = CHAR_SPACE;
    if (col < 16)
      ch = str_char(line, 4'(col));
  end

endmodule

// File: rtl/lcd_screen_sequencer.sv
// Owns the LCD character buffer; rewrites it from the message ROM on any
// change of {rooms, sword}, then runs one req/ack redraw handshake.
module lcd_screen_sequencer
  import lcd_pkg::*;
#(
  parameter int ROWS        = LCD_ROWS,
  parameter int COLS        = LCD_COLS,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                   CLOCK_50,
  input  logic                   Reset,
  input  logic [2:0]             rooms,
  input  logic                   sword,
  input  logic                   refresh_ack,
  input  logic                   lcd_busy,
  output logic [8*ROWS*COLS-1:0] chars,
  output logic                   refresh_req,
  output logic                   seq_busy,
  output logic                   timeout_err
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IW-1:0] LAST = IW'(CELLS - 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

  seq_state_t    state;
  seq_state_t    state_d;
  logic [IW-1:0] idx;
  logic [2:0]    rooms_q;
  logic          sword_q;
  logic [3:0]    last_shown;
  logic [TW-1:0] tcnt;
  logic [7:0]    rom_ch;

  logic evt;
  logic start;
  logic wr;
  logic done;
  logic req_d;
  logic t_clr;
  logic t_inc;
  logic err_set;

  lcd_msg_rom #(
    .ROWS (ROWS),
    .COLS (COLS),
    .IW   (IW)
  ) u_rom (
    .rooms (rooms_q),
    .sword (sword_q),
    .idx   (idx),
    .ch    (rom_ch)
  );

  assign evt      = ({rooms, sword} != last_shown);
  assign seq_busy = (state != IDLE);

  always_comb begin
    state_d = state;
    start   = 1'b0;
    wr      = 1'b0;
    done    = 1'b0;
    req_d   = 1'b0;
    t_clr   = 1'b0;
    t_inc   = 1'b0;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (evt) begin
          state_d = LOAD;
          start   = 1'b1;
        end
      end
      LOAD: begin
        wr = 1'b1;
        if (idx == LAST) begin
          done    = 1'b1;
          state_d = REQ;
          req_d   = 1'b1;
          t_clr   = 1'b1;
        end
      end
      REQ: begin
        // ack takes priority over an expiring timeout
        if (refresh_ack) begin
          state_d = WAIT;
        end else if (tcnt == TMAX) begin
          state_d = IDLE;
          err_set = 1'b1;
        end else begin
          req_d = 1'b1;
          t_inc = 1'b1;
        end
      end
      WAIT: begin
        if (!lcd_busy)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state       <= LOAD;
      idx         <= '0;
      rooms_q     <= '0;
      sword_q     <= 1'b0;
      last_shown  <= '0;
      tcnt        <= '0;
      refresh_req <= 1'b0;
      timeout_err <= 1'b0;
      chars       <= {CELLS{CHAR_SPACE}};
    end else begin
      state       <= state_d;
      refresh_req <= req_d;
      if (start) begin
        rooms_q <= rooms;
        sword_q <= sword;
        idx     <= '0;
      end else if (wr) begin
        chars[8*int'(idx) +: 8] <= rom_ch;
        idx <= done ? '0 : IW'(idx + 1'b1);
      end
      if (done)
        last_shown <= {rooms_q, sword_q};
      if (t_clr)
        tcnt <= '0;
      else if (t_inc && tcnt != '1)
        tcnt <= tcnt + 1'b1;
      if (err_set)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_screen_sequencer.sv
// Randomized and directed bench for lcd_screen_sequencer against a
// string-level screen model and an input-history redraw model.
module tb_lcd_screen_sequencer;

  localparam int TMO = 1024;

  logic         clk;
  logic         Reset;
  logic [2:0]   rooms;
  logic         sword;
  logic         refresh_ack;
  logic         lcd_busy;
  logic [255:0] chars;
  logic         refresh_req;
  logic         seq_busy;
  logic         timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  bit auto_ack  = 1;
  int ack_dly   = 0;
  int busy_len  = 5;
  bit post_reset = 1;

  logic [3:0] hist[$];
  logic [3:0] shown[$];
  logic [3:0] shown_v;
  int         req_rises = 0;
  logic       req_prev  = 0;

  lcd_screen_sequencer #(
    .ROWS        (2),
    .COLS        (16),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .CLOCK_50    (clk),
    .Reset       (Reset),
    .rooms       (rooms),
    .sword       (sword),
    .refresh_ack (refresh_ack),
    .lcd_busy    (lcd_busy),
    .chars       (chars),
    .refresh_req (refresh_req),
    .seq_busy    (seq_busy),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] screen(
    input logic [2:0] r,
    input logic       s
  );
    string l0;
    string l1;
    logic [255:0] v;
    case (r)
      3'd0:    l0 = "Cave";
      3'd1:    l0 = "Tunnel";
      3'd2:    l0 = "River";
      3'd3:    l0 = "Dungeon";
      3'd4:    l0 = "Vault";
      default: l0 = "????";
    endcase
    l1 = s ? "Sword: YES" : "Sword: NO";
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[8*k +: 8]      = (k < l0.len()) ? l0[k] : 8'h20;
      v[8*(16+k) +: 8] = (k < l1.len()) ? l1[k] : 8'h20;
    end
    return v;
  endfunction

  // LCD driver model: ack after ack_dly cycles, then busy for busy_len.
  initial begin
    refresh_ack = 0;
    lcd_busy    = 0;
    forever begin
      @(negedge clk);
      if (auto_ack && refresh_req && Reset) begin
        repeat (ack_dly) @(negedge clk);
        refresh_ack = 1;
        @(negedge clk);
        refresh_ack = 0;
        lcd_busy    = 1;
        repeat (busy_len) @(negedge clk);
        lcd_busy = 0;
      end
    end
  end

  // A screen is snapshotted 32 edges before its request rises.
  always @(posedge clk) begin
    hist.push_front({rooms, sword});
    if (hist.size() > 40)
      void'(hist.pop_back());
  end

  always @(negedge clk) begin
    if (refresh_req && !req_prev) begin
      req_rises++;
      if (post_reset)
        shown_v = 4'h0;
      else if (hist.size() > 32)
        shown_v = hist[32];
      else
        shown_v = 4'hF;
      post_reset = 0;
      shown.push_back(shown_v);
      check("screen_at_req", chars,
            screen(shown_v[3:1], shown_v[0]));
    end
    req_prev = refresh_req;
  end

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!seq_busy && !lcd_busy && !refresh_ack)
        quiet++;
      else
        quiet = 0;
    end
    check("idle_reached", 256'(quiet >= 3), 256'(1));
  endtask

  task automatic count_to_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!refresh_req && n < 100);
  endtask

  logic [255:0] old;
  logic [255:0] lowmask;
  int n;
  int r0;
  int s0;

  initial begin
    Reset = 0;
    rooms = 0;
    sword = 0;
    lowmask = (256'd1 << 184) - 256'd1;

    repeat (3) @(negedge clk);
    check("rst_chars", chars, {32{8'h20}});
    check("rst_req", 256'(refresh_req), 256'(0));
    check("rst_err", 256'(timeout_err), 256'(0));
    check("rst_busy", 256'(seq_busy), 256'(1));
    Reset = 1;

    // 1: power-up screen
    count_to_req(n);
    check("t1_lat", 256'(n), 256'(32));
    check("t1_screen", chars, screen(3'd0, 1'b0));

    // 2: handshake completes, no further request
    wait_idle(100);
    check("t2_idle", 256'(seq_busy), 256'(0));
    r0 = req_rises;
    repeat (50) @(negedge clk);
    check("t2_noreq", 256'(req_rises - r0), 256'(0));

    // 3: sword change rewrites only the sword status
    old = chars;
    r0  = req_rises;
    sword = 1;
    @(negedge clk);
    check("t3_busy", 256'(seq_busy), 256'(1));
    wait_idle(200);
    check("t3_screen", chars, screen(3'd0, 1'b1));
    check("t3_same", (old ^ chars) & lowmask, '0);
    check("t3_reqs", 256'(req_rises - r0), 256'(1));

    // 4: changes during LOAD collapse to one follow-up pass
    r0 = req_rises;
    s0 = shown.size();
    rooms = 1;
    repeat (5) @(negedge clk);
    rooms = 2;
    repeat (10) @(negedge clk);
    rooms = 3;
    repeat (200) @(negedge clk);
    wait_idle(200);
    check("t4_reqs", 256'(req_rises - r0), 256'(2));
    check("t4_pass1",
          256'((shown.size() > s0) ? shown[s0] : 4'hF),
          256'({3'd1, 1'b1}));
    check("t4_pass2",
          256'((shown.size() > s0 + 1) ? shown[s0+1] : 4'hF),
          256'({3'd3, 1'b1}));
    check("t4_screen", chars, screen(3'd3, 1'b1));

    // 5: missing ack times out; error is sticky
    check("t5_err0", 256'(timeout_err), 256'(0));
    auto_ack = 0;
    rooms = 4;
    count_to_req(n);
    n = 1;
    while (refresh_req && n < 3000) begin
      @(negedge clk);
      if (refresh_req) n++;
    end
    check("t5_reqlen", 256'(n), 256'(TMO));
    check("t5_err", 256'(timeout_err), 256'(1));
    check("t5_req", 256'(refresh_req), 256'(0));
    @(negedge clk);
    check("t5_idle", 256'(seq_busy), 256'(0));
    auto_ack = 1;
    rooms = 0;
    @(negedge clk);
    wait_idle(200);
    check("t5_screen", chars, screen(3'd0, 1'b1));
    check("t5_sticky", 256'(timeout_err), 256'(1));

    // 6: reset in the middle of LOAD
    rooms = 2;
    @(negedge clk);
    repeat (10) @(posedge clk);
    #2;
    Reset = 0;
    post_reset = 1;
    rooms = 0;
    sword = 0;
    #1;
    check("t6_chars", chars, {32{8'h20}});
    check("t6_req", 256'(refresh_req), 256'(0));
    check("t6_err", 256'(timeout_err), 256'(0));
    repeat (2) @(negedge clk);
    Reset = 1;
    count_to_req(n);
    check("t6_lat", 256'(n), 256'(32));
    check("t6_screen", chars, screen(3'd0, 1'b0));
    wait_idle(200);

    // random traffic
    for (int it = 0; it < 25; it++) begin
      ack_dly  = $urandom_range(0, 20);
      busy_len = $urandom_range(0, 10);
      rooms = 3'($urandom_range(0, 7));
      sword = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        rooms = 3'($urandom_range(0, 7));
        sword = 1'($urandom_range(0, 1));
      end
      wait_idle(400);
      check("rand_screen", chars, screen(rooms, sword));
      check("rand_err", 256'(timeout_err), 256'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
